// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time and
// hands {err, pc, inst} to the IF/ID register over valid/ready.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [XLEN-1:0]   mem_resp_data,
  input  logic              mem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN:0]   out_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   req_addr_q;
  logic              kill_q;
  logic [2*XLEN:0]   out_data_q;

  logic              ld_en;
  logic [XLEN-1:0]   ld_addr;
  logic              ld_misal;

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_resp_ready = (state_q == S_WAIT);
  assign out_valid      = (state_q == S_HOLD);
  assign mem_req_addr   = req_addr_q;
  assign out_data       = out_data_q;

  // ld_en marks every cycle that starts a fresh fetch at ld_addr
  always_comb begin
    ld_en   = 1'b0;
    ld_addr = pc_q;
    pc_d    = redirect_valid ? redirect_pc : pc_q;
    unique case (state_q)
      S_IDLE: begin
        ld_en   = 1'b1;
        ld_addr = redirect_valid ? redirect_pc : pc_q;
      end
      S_REQ: begin
      end
      S_WAIT: begin
        if (mem_resp_valid && (kill_q || redirect_valid)) begin
          ld_en   = 1'b1;
          ld_addr = redirect_valid ? redirect_pc : pc_q;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          ld_en   = 1'b1;
          ld_addr = redirect_pc;
        end else if (out_ready) begin
          ld_en   = 1'b1;
          ld_addr = pc_q + XLEN'(4);
          pc_d    = pc_q + XLEN'(4);
        end
      end
    endcase
    ld_misal = (ld_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (ld_en) begin
        req_addr_q <= ld_addr;
        kill_q     <= 1'b0;
        // misaligned targets fault locally without touching memory
        if (ld_misal) begin
          state_q    <= S_HOLD;
          out_data_q <= {1'b1, ld_addr, {XLEN{1'b0}}};
        end else begin
          state_q <= S_REQ;
        end
      end else begin
        unique case (state_q)
          S_REQ: begin
            if (redirect_valid) kill_q <= 1'b1;
            if (mem_req_ready) state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (mem_resp_valid) begin
              out_data_q <= {mem_resp_err, req_addr_q, mem_resp_data};
              state_q    <= S_HOLD;
            end else if (redirect_valid) begin
              kill_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
